// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, region-select encoding and a small window-compare helper.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_CAM_X0 = 160;
    localparam int DEF_CAM_Y0 = 120;
    localparam int DEF_CAM_W  = 320;
    localparam int DEF_CAM_H  = 240;

    typedef enum logic [1:0] {
        SEL_BLANK  = 2'd0,
        SEL_CAM    = 2'd1,
        SEL_BG     = 2'd2,
        SEL_BORDER = 2'd3
    } sel_t;

    // Half-open interval test lo <= v < hi on a 10-bit raster coordinate.
    function automatic logic in_range(input logic [9:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_region_decode.sv
// Maps a raster coordinate to the pixel-source select: blank, camera window, background or border.
module vga_region_decode
    import vga_timing_pkg::*;
#(
    parameter int CAM_X0 = DEF_CAM_X0,
    parameter int CAM_Y0 = DEF_CAM_Y0,
    parameter int CAM_W  = DEF_CAM_W,
    parameter int CAM_H  = DEF_CAM_H
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic       de_i,
    input  logic       border_i,
    output sel_t       sel_o
);

    logic in_win;
    logic on_edge;

    always_comb begin
        in_win  = in_range(x_i, CAM_X0, CAM_X0 + CAM_W) && in_range(y_i, CAM_Y0, CAM_Y0 + CAM_H);
        on_edge = (int'(x_i) == CAM_X0) || (int'(x_i) == CAM_X0 + CAM_W - 1) ||
                  (int'(y_i) == CAM_Y0) || (int'(y_i) == CAM_Y0 + CAM_H - 1);
        sel_o = SEL_BLANK;
        if (de_i) begin
            if (!in_win) begin
                sel_o = SEL_BG;
            end else if (border_i && on_edge) begin
                sel_o = SEL_BORDER;
            end else begin
                sel_o = SEL_CAM;
            end
        end
    end

endmodule

// File: rtl/vga_sel_gen.sv
// VGA raster counter producing position, syncs, de, region select and line/frame pulses,
// all decoded from the next coordinate so every output describes the same pixel.
module vga_sel_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_ACT = 1'b0,
    parameter int CAM_X0   = DEF_CAM_X0,
    parameter int CAM_Y0   = DEF_CAM_Y0,
    parameter int CAM_W    = DEF_CAM_W,
    parameter int CAM_H    = DEF_CAM_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       border_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [1:0] sel,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    if (CAM_X0 + CAM_W > H_ACTIVE) begin : g_chk_cam_x
        $error("camera window exceeds active width");
    end
    if (CAM_Y0 + CAM_H > V_ACTIVE) begin : g_chk_cam_y
        $error("camera window exceeds active height");
    end
    if (CAM_W < 2 || CAM_H < 2) begin : g_chk_cam_size
        $error("camera window must be at least 2x2");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_total
        $error("raster totals must fit 10-bit counters");
    end

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    sel_t       sel_q, sel_d;
    logic       frame_start_q;
    logic       line_start_q;
    logic       border_q, border_d;
    logic       frame_entry;

    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
        frame_entry = (x_d == '0) && (y_d == '0);
        // The entering pixel already sees the freshly latched border request.
        border_d = frame_entry ? border_en : border_q;
        de_d     = in_range(x_d, 0, H_ACTIVE) && in_range(y_d, 0, V_ACTIVE);
        hsync_d  = in_range(x_d, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? SYNC_ACT : ~SYNC_ACT;
        vsync_d  = in_range(y_d, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    end

    vga_region_decode #(
        .CAM_X0 (CAM_X0),
        .CAM_Y0 (CAM_Y0),
        .CAM_W  (CAM_W),
        .CAM_H  (CAM_H)
    ) u_region (
        .x_i      (x_d),
        .y_i      (y_d),
        .de_i     (de_d),
        .border_i (border_d),
        .sel_o    (sel_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            de_q          <= 1'b0;
            sel_q         <= SEL_BLANK;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            border_q      <= 1'b0;
        end else if (pix_en) begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            sel_q         <= sel_d;
            frame_start_q <= frame_entry;
            line_start_q  <= (x_d == '0);
            border_q      <= border_d;
        end else begin
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign sel         = sel_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule

// File: doc/vga_sel_gen.md
Name: vga_sel_gen

Overview:
- Upstream producer of the 2-bit pixel-source select that the downstream select delay line consumes.
- Generates VGA raster timing (x/y position, hsync, vsync, de) and a per-pixel region select (blank / camera window / game background / window border), all registered and mutually aligned.
- Sits between the clock-enable generator and the pixel mux pipeline; the downstream delay stages re-align sel with the pipelined pixel data.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_ACT, 0, asserted level of hsync/vsync (0 = active-low)
- CAM_X0, 160, camera window left column
- CAM_Y0, 120, camera window top line
- CAM_W, 320, camera window width
- CAM_H, 240, camera window height

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel-rate enable; raster advances only when high
- border_en  in  1  request to draw the window border; sampled per frame
- x  out  10  current column, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at SYNC_ACT polarity
- vsync  out  1  vertical sync at SYNC_ACT polarity
- de  out  1  1 when x<H_ACTIVE and y<V_ACTIVE
- sel  out  2  region select, encoding below
- frame_start  out  1  one-cycle pulse when the raster enters (0,0)
- line_start  out  1  one-cycle pulse when x enters 0

Behaviour:
- H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525).
- Reset, clk and reset are as stated above: reset is synchronous and active-high, and the clock is clk.
- Reset state loads x=H_TOTAL-1 and y=V_TOTAL-1, the last blank pixel.
- Reset values of the other outputs:
  - de=0, sel=0.
  - hsync and vsync are inactive (=!SYNC_ACT).
  - frame_start=0, line_start=0.
  - The latched border_en is 0.
- Advance: on a clk edge with pix_en=1:
  - x increments.
  - When x=H_TOTAL-1, x wraps to 0 and y increments.
  - When y=V_TOTAL-1 at that wrap, y wraps to 0.
- With pix_en=0, all outputs hold their values. The exception is frame_start and line_start, which are forced to 0.
- Alignment: hsync, vsync, de, sel and the pulses are decoded from the next (x,y) and registered in the same edge as x/y. All outputs therefore describe the same pixel, with zero skew and no extra latency.
- Sync windows:
  - hsync is active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
- sel encoding:
  - 0 = blank (de=0).
  - 1 = camera window interior.
  - 2 = game background (active, outside the window).
  - 3 = border: a pixel inside the window with x==CAM_X0, x==CAM_X0+CAM_W-1, y==CAM_Y0 or y==CAM_Y0+CAM_H-1, shown only when the latched border_en=1. Otherwise that pixel is 1.
- border_en is latched only on the advance that enters (0,0), so it is applied per frame. Mid-frame changes take effect on the next frame.
- line_start=1 on the advance into x=0 (every line). frame_start=1 only on the advance into (0,0).
- Reset mid-frame forces the reset state immediately. The next pix_en then produces frame_start.
- Elaboration checks:
  - CAM_X0+CAM_W <= H_ACTIVE.
  - CAM_Y0+CAM_H <= V_ACTIVE.
  - CAM_W >= 2 and CAM_H >= 2.
  - H_TOTAL and V_TOTAL are each <= 1024.

Decomposition:
- Shared package vga_timing_pkg:
  - sel_t enum: SEL_BLANK=0, SEL_CAM=1, SEL_BG=2, SEL_BORDER=3.
  - Default 640x480 timing constants.
  - Derived H_TOTAL and V_TOTAL.
- One natural sub-module, vga_region_decode: combinational mapping of (x, y, de, border_latched) to sel_t. It is reused by the overlay path and is instantiated on the next-state coordinates.

Test Plan:
- Reset, then hold pix_en=0 for 5 clocks -> x=799, y=524, de=0, sel=0, hsync=vsync=1, no pulses.
- Release with pix_en=1 every clock -> first edge gives x=0, y=0, frame_start=1, line_start=1, de=1, sel=2. After 640 edges, de=0 and sel=0.
- Free-run one line -> hsync=0 exactly for x=656..751 (96 cycles), line_start every 800 enabled cycles. Over a frame, vsync=0 for y=490..491 only, and frame_start recurs after 420000 enabled cycles.
- border_en=1 before frame start:
  - (160,120) -> sel=3; (161,121) -> sel=1; (479,359) -> sel=3; (480,120) -> sel=2.
  - Drop border_en mid-frame -> sel=3 persists until the next frame, then (160,120) gives sel=1.
- Enable pix_en 1-in-4 -> outputs change only on enabled edges, pulses last exactly one clk, and x/de/sel remain aligned.
- Assert reset at (300,200) for 1 clock -> the reset state is restored, and the next enabled edge gives (0,0) with frame_start=1.
